// File: rtl/uart_receive.sv
// 8N1 UART receiver: two-flop line synchroniser, start-edge detect, mid-bit
// sampling, one-cycle valid / frame_err strobes with a break-hold state.
module uart_receive #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] word,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             sync1_reg;
  logic             sync2_reg;
  logic             rx_s;

  assign rx_s = sync2_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      word        <= 8'h00;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sync1_reg <= rxd;
      sync2_reg <= sync1_reg;
      valid     <= 1'b0;
      frame_err <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (!rx_s) begin
            state_reg <= S_START;
            cnt_reg   <= '0;
            busy      <= 1'b1;
          end
        end

        // A line that is high again at mid-start was only a glitch.
        S_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (!rx_s) begin
              state_reg   <= S_DATA;
              bit_idx_reg <= '0;
            end else begin
              state_reg <= S_IDLE;
              busy      <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= S_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        // Returning to IDLE at the stop centre lets a back-to-back start edge
        // in the second half of the stop bit be caught.
        S_STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
              word      <= shift_reg;
              valid     <= 1'b1;
              state_reg <= S_IDLE;
              busy      <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state_reg <= S_BREAK;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          cnt_reg   <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: drives 8N1 frames on rxd and checks
// strobes, received words and strobe timing.
module tb_uart_receive;

  localparam int N = 16;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] word;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int total;
  int bad;
  int cyc;
  int fall_cyc;
  int valid_cnt;
  int ferr_cnt;
  int dbl_cnt;
  int overlap_cnt;
  logic busy_seen;
  logic prev_valid;
  logic prev_ferr;
  logic [7:0] vwords[$];
  int         vcycs[$];

  uart_receive #(.CLKS_PER_BIT(N), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .word      (word),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt <= valid_cnt + 1;
      vwords.push_back(word);
      vcycs.push_back(cyc);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if ((valid && prev_valid) || (frame_err && prev_ferr)) dbl_cnt <= dbl_cnt + 1;
    if (valid && frame_err) overlap_cnt <= overlap_cnt + 1;
    if (busy) busy_seen <= 1'b1;
    prev_valid <= valid;
    prev_ferr  <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * N) @(posedge clk);
    #1;
  endtask

  initial begin
    int v0;
    int f0;
    total = 0; bad = 0; cyc = 0;
    valid_cnt = 0; ferr_cnt = 0; dbl_cnt = 0; overlap_cnt = 0;
    busy_seen = 1'b0; prev_valid = 1'b0; prev_ferr = 1'b0;
    rst = 1'b0;
    rxd = 1'b1;

    // 1: reset held while rxd toggles
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      rxd = ~rxd;
    end
    rxd = 1'b1;
    check("rst_word", word, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy_seen", busy_seen, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_bits(2);

    // 2: single frame 8'h81
    vwords.delete(); vcycs.delete();
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    check("t2_count", vwords.size(), 1);
    check("t2_word", vwords[0], 8'h81);
    check("t2_latency", vcycs[0] - fall_cyc, 155);
    check("t2_ferr", ferr_cnt, 0);
    check("t2_busy", busy, 1'b0);

    // 3: back-to-back 8'h55, 8'hAA with no idle gap
    vwords.delete(); vcycs.delete();
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle_bits(2);
    check("t3_count", vwords.size(), 2);
    check("t3_word0", vwords[0], 8'h55);
    check("t3_word1", vwords[1], 8'hAA);
    check("t3_spacing", vcycs[1] - vcycs[0], 10 * N);
    check("t3_ferr", ferr_cnt, 0);

    // 4: short low glitch
    v0 = valid_cnt;
    busy_seen = 1'b0;
    rxd = 1'b0;
    repeat (N / 4) @(posedge clk);
    #1;
    idle_bits(2);
    check("t4_busy_seen", busy_seen, 1'b1);
    check("t4_busy_end", busy, 1'b0);
    check("t4_valid", valid_cnt, v0);
    check("t4_ferr", ferr_cnt, 0);

    // 5: framing error with line held low for three bit times
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (2 * N) @(posedge clk);
    #1;
    check("t5_busy_break", busy, 1'b1);
    idle_bits(2);
    check("t5_ferr", ferr_cnt - f0, 1);
    check("t5_valid", valid_cnt, v0);
    check("t5_word_kept", word, 8'hAA);
    check("t5_busy_end", busy, 1'b0);
    vwords.delete(); vcycs.delete();
    send_frame(8'h12, 1'b1);
    idle_bits(2);
    check("t5_next_count", vwords.size(), 1);
    check("t5_next_word", word, 8'h12);

    // 6: reset at bit 4 of 8'hF0
    v0 = valid_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t6_word", word, 8'h00);
    check("t6_busy", busy, 1'b0);
    check("t6_valid", valid, 1'b0);
    check("t6_ferr", frame_err, 1'b0);
    repeat (N) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_bits(1);
    check("t6_no_partial", valid_cnt, v0);
    vwords.delete(); vcycs.delete();
    send_frame(8'h0F, 1'b1);
    idle_bits(2);
    check("t6_count", vwords.size(), 1);
    check("t6_rx_word", vwords[0], 8'h0F);

    check("strobe_width", dbl_cnt, 0);
    check("strobe_exclusive", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
